// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD seven-segment display scanner.
//   SEG_0..SEG_9, SEG_DASH, SEG_OFF : active-high segment patterns {g,f,e,d,c,b,a}
//   state_t (ST_BLANK / ST_DRIVE)   : scan slot phase encoding
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to seven-segment decoder, active-high outputs.
// Non-BCD nibbles (A-F) produce a dash. Polarity is handled by the caller.
//   nib : input nibble
//   seg : segments {g,f,e,d,c,b,a}, 1 = lit
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner for the decade counter chain.
// Digits are double-buffered (shadow -> active at a frame boundary) so a new
// value never tears across a frame. Each slot starts with BLANK_CYCLES of
// all-anodes-off ghost blanking, then drives one digit.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 is never blanked; decimal points are unaffected).
//   clk, rst_n  : clock, asynchronous active-low reset
//   digits_bcd  : packed BCD digits, [3:0] = digit 0 (rightmost)
//   load        : capture strobe for digits_bcd and dp_mask
//   dp_mask     : decimal point enable per digit
//   seg, dp, an : segment / decimal point / digit enables (registered)
//   digit_idx   : digit presented on an/seg/dp (registered, aligned with them)
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter bit COMMON_ANODE = 1'b1,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int               PRE_W      = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] pol_seg(input logic [6:0] s);
    return COMMON_ANODE ? ~s : s;
  endfunction

  function automatic logic pol_dp(input logic d);
    return COMMON_ANODE ? ~d : d;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] pol_an(input logic [NUM_DIGITS-1:0] a);
    return COMMON_ANODE ? ~a : a;
  endfunction

  logic [PRE_W-1:0]               pre_q;
  logic [IDX_W-1:0]               scan_idx_q;
  state_t                         state_q;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q;
  logic [NUM_DIGITS-1:0][3:0]     active_q;
  logic [NUM_DIGITS-1:0]          dp_shadow_q;
  logic [NUM_DIGITS-1:0]          dp_active_q;
  logic                           pending_q;
  // Set once a value has reached the active buffer; until then the display
  // stays dark even though the scan runs.
  logic                           shown_q;
  logic                           boundary;
  logic [6:0]                     seg_dec;
  logic [6:0]                     seg_drv;
  logic [NUM_DIGITS-1:0]          an_onehot;

  assign boundary  = (pre_q == PRE_LAST) && (scan_idx_q == IDX_LAST);
  assign an_onehot = NUM_DIGITS'(1) << scan_idx_q;

  // Slot timing and phase FSM: state tracks the current prescaler value,
  // so it is BLANK for prescaler 0..BLANK_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      scan_idx_q <= '0;
      state_q    <= ST_BLANK;
    end else if (pre_q == PRE_LAST) begin
      pre_q      <= '0;
      scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
      state_q    <= ST_BLANK;
    end else begin
      pre_q      <= pre_q + 1'b1;
      state_q    <= (pre_q < BLANK_LAST) ? ST_BLANK : ST_DRIVE;
    end
  end

  // Double buffer. A load landing on the boundary cycle bypasses the shadow
  // so it is not delayed by a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      dp_shadow_q <= '0;
      dp_active_q <= '0;
      pending_q   <= 1'b0;
      shown_q     <= 1'b0;
    end else if (load && boundary) begin
      shadow_q    <= digits_bcd;
      dp_shadow_q <= dp_mask;
      active_q    <= digits_bcd;
      dp_active_q <= dp_mask;
      pending_q   <= 1'b0;
      shown_q     <= 1'b1;
    end else if (load) begin
      shadow_q    <= digits_bcd;
      dp_shadow_q <= dp_mask;
      pending_q   <= 1'b1;
    end else if (boundary && pending_q) begin
      active_q    <= shadow_q;
      dp_active_q <= dp_shadow_q;
      pending_q   <= 1'b0;
      shown_q     <= 1'b1;
    end
  end

  bcd_to_7seg u_dec (
    .nib (active_q[scan_idx_q]),
    .seg (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero  = upper_zero & (active_q[k] == 4'd0);
      lz_blank[k] = upper_zero;
    end
  end

  assign seg_drv = (lz_blank[scan_idx_q] || !shown_q) ? SEG_OFF : seg_dec;
`else
  assign seg_drv = shown_q ? seg_dec : SEG_OFF;
`endif

  // Output register stage: pins lag the FSM state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an        <= pol_an('0);
      seg       <= pol_seg(SEG_OFF);
      dp        <= pol_dp(1'b0);
      digit_idx <= '0;
    end else begin
      digit_idx <= scan_idx_q;
      if (state_q == ST_DRIVE) begin
        an  <= pol_an(an_onehot);
        seg <= pol_seg(seg_drv);
        dp  <= pol_dp(dp_active_q[scan_idx_q] & shown_q);
      end else begin
        an  <= pol_an('0);
        seg <= pol_seg(SEG_OFF);
        dp  <= pol_dp(1'b0);
      end
    end
  end

endmodule
